motor_drive_sequencer: RTL
==========================

Name: motor_drive_sequencer

Overview:
- Sequences the rover's H-bridge from operator speed/direction requests and the IPS track sensor.
- Decodes the three speed-select switches to a target PWM duty and generates PWM internally (32768-clock period).
- Ramps duty toward the target, forces a ramp-down plus dead-time before any direction reversal, and cuts drive immediately when IPS is lost.
- Sits between switch/JMOD inputs and the JC H-bridge pins, replacing the direct switch-to-H-bridge wiring.

Parameters:
- PWM_BITS, 15: PWM counter width; period is 2^PWM_BITS clocks.
- DUTY1, 23550: speed 1 compare value (~72%).
- DUTY2, 26555: speed 2 compare value (~81%).
- DUTY3, 32768: speed 3 compare value (always high).
- RAMP_STEP, 4096: maximum duty change per PWM period.
- DEAD_CYCLES, 1000: clocks with all bridge inputs low during reversal.

Ports:
- clk, input, 1: system clock (100 MHz).
- rst_n, input, 1: asynchronous active-low reset.
- speed_req, input, 3: speed select, one-hot; bit0 = speed 1, bit1 = speed 2, bit2 = speed 3.
- dir_req, input, 1: 0 = forward, 1 = reverse.
- ips_n, input, 1: IPS sensor; low = track detected, drive permitted. Asynchronous.
- en_a, output, 1: bridge enable A (PWM).
- en_b, output, 1: bridge enable B; always equal to en_a.
- in1, output, 1: bridge input 1.
- in2, output, 1: bridge input 2.
- in3, output, 1: bridge input 3.
- in4, output, 1: bridge input 4.
- state, output, 3: FSM state code.
- duty_cur, output, PWM_BITS+1: applied duty value.
- sel_err, output, 1: high when more than one speed bit is set.

Behaviour:
- Reset (async, rst_n low):
  - pwm_cnt = 0, duty_cur = 0, dir_applied = 0, dead_cnt = 0.
  - IPS synchronizer flops = 1 (not ok).
  - state = IDLE (0).
  - All outputs 0.
- IPS synchronizer: ips_n passes through 2 flops; ips_ok = ~synchronized ips_n.
- PWM counter: pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps to 0. tick = (pwm_cnt == all-ones).
- Target duty (combinational):
  - speed_req 001 -> DUTY1; 010 -> DUTY2; 100 -> DUTY3.
  - 000 -> 0.
  - Any multi-bit value -> 0, with sel_err = 1 (registered, 1-cycle latency).
- Ramp:
  - duty_cur changes only on tick, moving toward the effective target by min(RAMP_STEP, |target - duty_cur|).
  - Effective target is forced to 0 in RAMP_DOWN.
- PWM output: pwm_hi = (pwm_cnt < duty_cur), compared in PWM_BITS+1 bits.
- Drive decode:
  - en_a = en_b = pwm_hi in RUN/RAMP_DOWN, else 0.
  - Forward: in1 = in4 = 1, in2 = in3 = 0. Reverse: swapped.
  - All in* = 0 in IDLE, DEAD and HALT.
  - All outputs registered.
- States:
  - IDLE (0): -> RUN when target != 0 and ips_ok; latch dir_applied = dir_req on exit.
  - RUN (1):
    - ips_ok low -> HALT (priority over all).
    - Else dir_req != dir_applied -> RAMP_DOWN.
    - Else on tick with duty_cur == 0 and target == 0 -> IDLE.
  - RAMP_DOWN (2):
    - ips_ok low -> HALT.
    - Else dir_req == dir_applied again -> RUN (ramp resumes from current duty).
    - Else tick with duty_cur == 0 -> DEAD, dead_cnt = 0.
  - DEAD (3):
    - dead_cnt increments each clock.
    - At dead_cnt == DEAD_CYCLES-1 -> RUN, dir_applied = dir_req sampled at that cycle.
    - dir_req changes before then are ignored.
    - ips_ok low -> HALT.
  - HALT (4):
    - duty_cur forced to 0 immediately; outputs off.
    - ips_ok high -> IDLE.
- Boundaries:
  - Speed change in RUN ramps without a state change.
  - Simultaneous tick and dir change: the state transition wins and the ramp step is still applied.
  - DUTY3 yields constant en high once reached.
  - Reset mid-operation drops all outputs asynchronously.
- Latency:
  - ips_n falling/rising -> en change within 4 clocks.
  - Request change -> first duty step at the next tick.

Test Plan:
- Reset, ips_n = 0, speed_req = 001, dir_req = 0 -> IDLE->RUN, in1 = in4 = 1; duty_cur steps 4096, 8192 … 20480, then 23550 at the 6th tick; en high 23550 of 32768 clocks thereafter.
- Steady speed 2 then set speed_req = 100 -> duty_cur climbs from 26555 to 30651 to 32768; en_a constantly high.
- RUN at DUTY1, flip dir_req = 1 -> RAMP_DOWN; duty reaches 0 after 6 ticks; DEAD with all in* = 0 for exactly 1000 clocks; RUN with in2 = in3 = 1; ramp restarts from 0.
- Flip dir_req back during RAMP_DOWN at duty 12288 -> returns to RUN, ramps up from 12288, and bridge inputs never go low.
- speed_req = 011 -> sel_err = 1 one cycle later; duty ramps to 0; RUN->IDLE; outputs 0.
- ips_n goes high in RUN at DUTY2 -> en_a = 0 within 4 clocks, HALT, duty_cur = 0. ips_n low -> IDLE->RUN, ramp from 0.
- rst_n asserted mid-DEAD -> all outputs 0 immediately; state = 0.

Source files
------------

// File: rtl/motor_drive_sequencer.sv
// H-bridge sequencer: speed-switch decode, internal PWM with duty ramping,
// ramp-down plus dead-time on direction reversal, and IPS-loss cut-off.
module motor_drive_sequencer #(
   parameter int PWM_BITS    = 15,
   parameter int DUTY1       = 23550,
   parameter int DUTY2       = 26555,
   parameter int DUTY3       = 32768,
   parameter int RAMP_STEP   = 4096,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        speed_req,
   input  logic              dir_req,
   input  logic              ips_n,
   output logic              en_a,
   output logic              en_b,
   output logic              in1,
   output logic              in2,
   output logic              in3,
   output logic              in4,
   output logic [2:0]        state,
   output logic [PWM_BITS:0] duty_cur,
   output logic              sel_err
);

   // state     | meaning
   // IDLE (0)  | no drive, waiting for a non-zero target with track present
   // RUN (1)   | driving in dir_applied, duty ramps toward the switch target
   // RAMP_DOWN | reversal requested, duty ramps to zero in the old direction
   // DEAD (3)  | all bridge inputs low for DEAD_CYCLES before re-driving
   // HALT (4)  | track lost, duty zeroed, waiting for IPS to return

   localparam int DW = PWM_BITS + 1;
   localparam int CW = $clog2(DEAD_CYCLES + 1);

   localparam logic [DW-1:0] DUTY1_C   = DW'(DUTY1);
   localparam logic [DW-1:0] DUTY2_C   = DW'(DUTY2);
   localparam logic [DW-1:0] DUTY3_C   = DW'(DUTY3);
   localparam logic [DW-1:0] STEP_C    = DW'(RAMP_STEP);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RUN       = 3'd1,
      S_RAMP_DOWN = 3'd2,
      S_DEAD      = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [DW-1:0]       duty_q, duty_d;
   logic                dir_applied_q, dir_applied_d;
   logic [CW-1:0]       dead_cnt_q, dead_cnt_d;
   logic [1:0]          ips_sync_q;
   logic                sel_err_q;
   logic                en_q;
   logic [3:0]          in_q;

   logic                ips_ok;
   logic                tick;
   logic [DW-1:0]       target;
   logic                multi_sel;
   logic [DW-1:0]       eff_target;
   logic [DW-1:0]       diff;
   logic [DW-1:0]       step;
   logic [DW-1:0]       ramped;
   logic                drive;
   logic                pwm_hi;

   assign ips_ok = ~ips_sync_q[1];
   assign tick   = (pwm_cnt_q == '1);

   always_comb begin
      target    = '0;
      multi_sel = (speed_req[0] & speed_req[1]) | (speed_req[0] & speed_req[2]) |
                  (speed_req[1] & speed_req[2]);
      case (speed_req)
         3'b001:  target = DUTY1_C;
         3'b010:  target = DUTY2_C;
         3'b100:  target = DUTY3_C;
         default: target = '0;
      endcase
   end

   // Only RUN ramps toward the switch target; every other state pulls duty to zero.
   always_comb begin
      eff_target = (state_q == S_RUN) ? target : '0;
      diff       = '0;
      step       = '0;
      ramped     = duty_q;
      if (duty_q < eff_target) begin
         diff   = eff_target - duty_q;
         step   = (diff > STEP_C) ? STEP_C : diff;
         ramped = duty_q + step;
      end else begin
         diff   = duty_q - eff_target;
         step   = (diff > STEP_C) ? STEP_C : diff;
         ramped = duty_q - step;
      end
   end

   always_comb begin
      state_d       = state_q;
      dir_applied_d = dir_applied_q;
      dead_cnt_d    = dead_cnt_q;
      duty_d        = tick ? ramped : duty_q;
      case (state_q)
         S_IDLE: begin
            if (target != '0 && ips_ok) begin
               state_d       = S_RUN;
               dir_applied_d = dir_req;
            end
         end
         S_RUN: begin
            if (!ips_ok) begin
               state_d = S_HALT;
            end else if (dir_req != dir_applied_q) begin
               state_d = S_RAMP_DOWN;
            end else if (tick && duty_q == '0 && target == '0) begin
               state_d = S_IDLE;
            end
         end
         S_RAMP_DOWN: begin
            if (!ips_ok) begin
               state_d = S_HALT;
            end else if (dir_req == dir_applied_q) begin
               state_d = S_RUN;
            end else if (tick && duty_q == '0) begin
               state_d    = S_DEAD;
               dead_cnt_d = '0;
            end
         end
         S_DEAD: begin
            dead_cnt_d = dead_cnt_q + 1'b1;
            if (!ips_ok) begin
               state_d = S_HALT;
            end else if (dead_cnt_q == DEAD_LAST) begin
               state_d       = S_RUN;
               dir_applied_d = dir_req;
               dead_cnt_d    = '0;
            end
         end
         S_HALT: begin
            if (ips_ok) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_HALT) begin
         duty_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pwm_cnt_q     <= '0;
         duty_q        <= '0;
         dir_applied_q <= 1'b0;
         dead_cnt_q    <= '0;
         ips_sync_q    <= 2'b11;
         sel_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pwm_cnt_q     <= pwm_cnt_q + 1'b1;
         duty_q        <= duty_d;
         dir_applied_q <= dir_applied_d;
         dead_cnt_q    <= dead_cnt_d;
         ips_sync_q    <= {ips_sync_q[0], ips_n};
         sel_err_q     <= multi_sel;
      end
   end

   // Bridge decode registered from current state; bit0 = in1 .. bit3 = in4.
   assign drive  = (state_q == S_RUN) || (state_q == S_RAMP_DOWN);
   assign pwm_hi = ({1'b0, pwm_cnt_q} < duty_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 1'b0;
         in_q <= 4'b0000;
      end else begin
         en_q <= drive & pwm_hi;
         if (drive) begin
            in_q <= dir_applied_q ? 4'b0110 : 4'b1001;
         end else begin
            in_q <= 4'b0000;
         end
      end
   end

   assign en_a     = en_q;
   assign en_b     = en_q;
   assign in1      = in_q[0];
   assign in2      = in_q[1];
   assign in3      = in_q[2];
   assign in4      = in_q[3];
   assign state    = state_q;
   assign duty_cur = duty_q;
   assign sel_err  = sel_err_q;

endmodule
